// File: rtl/song_pkg.sv
// Shared types, note/LED codes and library geometry for the auto-play song sequencer.
package song_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_PLAY   = 3'd2,
        ST_GAP    = 3'd3,
        ST_PAUSED = 3'd4
    } state_t;

    typedef logic [3:0] note_t;

    localparam note_t END_CODE  = 4'hF;
    localparam note_t NOTE_REST = 4'd0;
    localparam note_t NOTE_1    = 4'd1;
    localparam note_t NOTE_2    = 4'd2;
    localparam note_t NOTE_3    = 4'd3;
    localparam note_t NOTE_4    = 4'd4;
    localparam note_t NOTE_5    = 4'd5;
    localparam note_t NOTE_6    = 4'd6;
    localparam note_t NOTE_7    = 4'd7;

    localparam logic [6:0] LED_OFF = 7'b0000000;
    localparam logic [6:0] LED_1   = 7'b0000001;
    localparam logic [6:0] LED_2   = 7'b0000010;
    localparam logic [6:0] LED_3   = 7'b0000100;
    localparam logic [6:0] LED_4   = 7'b0001000;
    localparam logic [6:0] LED_5   = 7'b0010000;
    localparam logic [6:0] LED_6   = 7'b0100000;
    localparam logic [6:0] LED_7   = 7'b1000000;

    localparam int NUM_SONGS = 3;
    localparam int SONG_LEN  = 56;

    function automatic logic [6:0] note_to_led(input note_t n);
        case (n)
            NOTE_1:  return LED_1;
            NOTE_2:  return LED_2;
            NOTE_3:  return LED_3;
            NOTE_4:  return LED_4;
            NOTE_5:  return LED_5;
            NOTE_6:  return LED_6;
            NOTE_7:  return LED_7;
            default: return LED_OFF;
        endcase
    endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// Button, song-library and buzzer/LED signals between the sequencer and its surroundings.
interface song_sequencer_if;
    import song_pkg::*;

    logic        btn_next;
    logic        btn_prev;
    logic        btn_play;
    note_t       lib_note;
    logic [3:0]  lib_dur;
    logic [1:0]  song_num;
    logic [5:0]  lib_addr;
    note_t       note_to_play;
    logic [6:0]  led_out;
    logic        playing;
    logic        song_done;

    modport master (
        input  btn_next, btn_prev, btn_play, lib_note, lib_dur,
        output song_num, lib_addr, note_to_play, led_out, playing, song_done
    );

    modport slave (
        output btn_next, btn_prev, btn_play, lib_note, lib_dur,
        input  song_num, lib_addr, note_to_play, led_out, playing, song_done
    );

endinterface

// File: rtl/song_sequencer_rise_detect.sv
// Registered rising-edge detector: one-cycle pulse the cycle after a level goes high.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q <= 1'b0;
            rise    <= 1'b0;
        end else begin
            level_q <= level;
            rise    <= level & ~level_q;
        end
    end

endmodule

// File: rtl/song_sequencer.sv
// Auto-play controller: walks the song library, times each note, gaps between notes,
// handles play/pause and song navigation, and drives the buzzer code and note LEDs.
module song_sequencer
    import song_pkg::*;
#(
    parameter int    TICKS_PER_UNIT = 17500000,
    parameter int    GAP_TICKS      = 1000000,
    parameter int    SONG_LEN       = song_pkg::SONG_LEN,
    parameter int    NUM_SONGS      = song_pkg::NUM_SONGS,
    parameter note_t END_CODE       = song_pkg::END_CODE
) (
    input  logic              clk,
    input  logic              reset,
    song_sequencer_if.master  bus
);

    localparam int TICK_MAX = (TICKS_PER_UNIT > GAP_TICKS) ? TICKS_PER_UNIT : GAP_TICKS;
    localparam int TW       = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_UNIT - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [1:0]    SONG_LAST = 2'(NUM_SONGS - 1);
    localparam logic [5:0]    ADDR_LAST = 6'(SONG_LEN - 1);

    logic next_p, prev_p, play_p;

    rise_detect u_next (.clk(clk), .reset(reset), .level(bus.btn_next), .rise(next_p));
    rise_detect u_prev (.clk(clk), .reset(reset), .level(bus.btn_prev), .rise(prev_p));
    rise_detect u_play (.clk(clk), .reset(reset), .level(bus.btn_play), .rise(play_p));

    state_t        state, state_nxt, resume, resume_nxt;
    logic [TW-1:0] tick, tick_nxt;
    logic [3:0]    unit, unit_nxt;
    note_t         note_h, note_h_nxt;
    logic [3:0]    dur_h, dur_h_nxt;
    logic [1:0]    song_q, song_nxt;
    logic [5:0]    addr_q, addr_nxt;
    note_t         note_q, note_nxt;
    logic [6:0]    led_q, led_nxt;
    logic          playing_q, playing_nxt;
    logic          done_q, done_nxt;
    logic          advance;

    always_comb begin
        state_nxt  = state;
        resume_nxt = resume;
        tick_nxt   = tick;
        unit_nxt   = unit;
        note_h_nxt = note_h;
        dur_h_nxt  = dur_h;
        song_nxt   = song_q;
        addr_nxt   = addr_q;
        done_nxt   = 1'b0;
        advance    = 1'b0;

        if (next_p || prev_p) begin
            if (next_p)
                song_nxt = (song_q == SONG_LAST) ? 2'd0 : song_q + 2'd1;
            else
                song_nxt = (song_q == 2'd0) ? SONG_LAST : song_q - 2'd1;
            addr_nxt = '0;
            tick_nxt = '0;
            unit_nxt = '0;
            if (state == ST_PAUSED)
                resume_nxt = ST_LOAD;
            else if (state != ST_IDLE)
                state_nxt = ST_LOAD;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (play_p) begin
                        state_nxt = ST_LOAD;
                        addr_nxt  = '0;
                    end
                end
                ST_LOAD: begin
                    if (play_p) begin
                        state_nxt  = ST_PAUSED;
                        resume_nxt = ST_LOAD;
                    end else if (bus.lib_note == END_CODE) begin
                        if (addr_q == 6'd0) begin
                            state_nxt = ST_IDLE;
                        end else begin
                            addr_nxt = '0;
                            done_nxt = 1'b1;
                        end
                    end else begin
                        note_h_nxt = bus.lib_note;
                        dur_h_nxt  = (bus.lib_dur == 4'd0) ? 4'd1 : bus.lib_dur;
                        tick_nxt   = '0;
                        unit_nxt   = '0;
                        state_nxt  = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (tick == TICK_LAST) begin
                        tick_nxt = '0;
                        if (unit == dur_h - 4'd1) begin
                            unit_nxt = '0;
                            if (GAP_TICKS > 0)
                                state_nxt = ST_GAP;
                            else
                                advance = 1'b1;
                        end else begin
                            unit_nxt = unit + 4'd1;
                        end
                    end else begin
                        tick_nxt = tick + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (tick == GAP_LAST) begin
                        tick_nxt = '0;
                        advance  = 1'b1;
                    end else begin
                        tick_nxt = tick + 1'b1;
                    end
                end
                ST_PAUSED: begin
                    if (play_p)
                        state_nxt = resume;
                end
                default: state_nxt = ST_IDLE;
            endcase

            if (advance) begin
                if (addr_q == ADDR_LAST) begin
                    addr_nxt = '0;
                    done_nxt = 1'b1;
                end else begin
                    addr_nxt = addr_q + 6'd1;
                end
                state_nxt = ST_LOAD;
            end

            // The pausing cycle still sounded, so its count step stands and the
            // step's destination becomes the resume target.
            if (play_p && (state == ST_PLAY || state == ST_GAP)) begin
                resume_nxt = state_nxt;
                state_nxt  = ST_PAUSED;
            end
        end

        note_nxt    = (state_nxt == ST_PLAY) ? note_h_nxt : NOTE_REST;
        led_nxt     = note_to_led(note_nxt);
        playing_nxt = (state_nxt == ST_LOAD) || (state_nxt == ST_PLAY) || (state_nxt == ST_GAP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            resume    <= ST_LOAD;
            tick      <= '0;
            unit      <= '0;
            note_h    <= NOTE_REST;
            dur_h     <= 4'd0;
            song_q    <= 2'd0;
            addr_q    <= 6'd0;
            note_q    <= NOTE_REST;
            led_q     <= LED_OFF;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            resume    <= resume_nxt;
            tick      <= tick_nxt;
            unit      <= unit_nxt;
            note_h    <= note_h_nxt;
            dur_h     <= dur_h_nxt;
            song_q    <= song_nxt;
            addr_q    <= addr_nxt;
            note_q    <= note_nxt;
            led_q     <= led_nxt;
            playing_q <= playing_nxt;
            done_q    <= done_nxt;
        end
    end

    assign bus.song_num     = song_q;
    assign bus.lib_addr     = addr_q;
    assign bus.note_to_play = note_q;
    assign bus.led_out      = led_q;
    assign bus.playing      = playing_q;
    assign bus.song_done    = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with a tiny three-song library (4 ticks/unit, 2-tick gap, 4 slots).
module tb_song_sequencer;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    song_sequencer_if bus ();

    song_sequencer #(
        .TICKS_PER_UNIT(4),
        .GAP_TICKS(2),
        .SONG_LEN(4),
        .NUM_SONGS(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Song 0: (1,2) (3,1) (5,0) END; song 1: empty; song 2: (2,1) in every slot.
    always_comb begin
        bus.lib_note = 4'd0;
        bus.lib_dur  = 4'd0;
        case ({bus.song_num, bus.lib_addr[1:0]})
            4'b00_00: begin bus.lib_note = 4'd1; bus.lib_dur = 4'd2; end
            4'b00_01: begin bus.lib_note = 4'd3; bus.lib_dur = 4'd1; end
            4'b00_10: begin bus.lib_note = 4'd5; bus.lib_dur = 4'd0; end
            4'b00_11: begin bus.lib_note = 4'hF; bus.lib_dur = 4'd0; end
            4'b01_00, 4'b01_01, 4'b01_10, 4'b01_11: begin bus.lib_note = 4'hF; bus.lib_dur = 4'd0; end
            4'b10_00, 4'b10_01, 4'b10_10, 4'b10_11: begin bus.lib_note = 4'd2; bus.lib_dur = 4'd1; end
            default: begin bus.lib_note = 4'd0; bus.lib_dur = 4'd0; end
        endcase
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.btn_next = 1'b0;
        bus.btn_prev = 1'b0;
        bus.btn_play = 1'b0;
        #20;
        reset = 1'b1;
        cyc();
        n_cmp++;
        if ({bus.song_num, bus.lib_addr} !== 8'd0) begin
            n_bad++; $display("FAIL reset_song_addr got=%h exp=00", {bus.song_num, bus.lib_addr});
        end
        n_cmp++;
        if ({bus.note_to_play, bus.led_out, bus.playing, bus.song_done} !== 13'd0) begin
            n_bad++; $display("FAIL reset_outputs got=%h exp=0000", {bus.note_to_play, bus.led_out, bus.playing, bus.song_done});
        end
    endtask

    task automatic test_song0_play();
        logic [3:0] exp_note [27];
        exp_note = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0,
                     4'd3, 4'd3, 4'd3, 4'd3, 4'd0, 4'd0, 4'd0,
                     4'd5, 4'd5, 4'd5, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1};
        bus.btn_play = 1'b1;
        cyc();
        bus.btn_play = 1'b0;
        cyc();
        n_cmp++;
        if (bus.playing !== 1'b1 || bus.note_to_play !== 4'd0) begin
            n_bad++; $display("FAIL play_load got playing=%b note=%h exp playing=1 note=0", bus.playing, bus.note_to_play);
        end
        for (int i = 0; i < 27; i++) begin
            cyc();
            n_cmp++;
            if (bus.note_to_play !== exp_note[i]) begin
                n_bad++; $display("FAIL song0_note[%0d] got=%h exp=%h", i, bus.note_to_play, exp_note[i]);
            end
            n_cmp++;
            if (bus.song_done !== (i == 25)) begin
                n_bad++; $display("FAIL song0_done[%0d] got=%b exp=%b", i, bus.song_done, (i == 25));
            end
            if (i == 0 || i == 9 || i == 11 || i == 18) begin
                logic [6:0] exp_led;
                exp_led = (i == 0) ? 7'b0000001 : (i == 11) ? 7'b0000100 : (i == 18) ? 7'b0010000 : 7'b0000000;
                n_cmp++;
                if (bus.led_out !== exp_led) begin
                    n_bad++; $display("FAIL song0_led[%0d] got=%b exp=%b", i, bus.led_out, exp_led);
                end
            end
            if (i == 25) begin
                n_cmp++;
                if (bus.lib_addr !== 6'd0) begin
                    n_bad++; $display("FAIL song0_wrap_addr got=%0d exp=0", bus.lib_addr);
                end
            end
        end
    endtask

    task automatic test_reset_mid_play();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc();
            if (bus.note_to_play == 4'd5) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++; $display("FAIL midplay_reach_note5 got=timeout exp=note 5");
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({bus.note_to_play, bus.led_out, bus.playing, bus.song_num, bus.lib_addr} !== 20'd0) begin
            n_bad++; $display("FAIL midplay_async_reset got=%h exp=00000",
                              {bus.note_to_play, bus.led_out, bus.playing, bus.song_num, bus.lib_addr});
        end
        #3;
        reset = 1'b1;
        cyc();
        cyc();
        n_cmp++;
        if (bus.playing !== 1'b0 || bus.note_to_play !== 4'd0) begin
            n_bad++; $display("FAIL midplay_idle got playing=%b note=%h exp 0/0", bus.playing, bus.note_to_play);
        end
    endtask

    task automatic test_pause();
        bus.btn_play = 1'b1;
        cyc();
        bus.btn_play = 1'b0;
        cyc();
        cyc();
        cyc();
        bus.btn_play = 1'b1;
        cyc();
        n_cmp++;
        if (bus.note_to_play !== 4'd1) begin
            n_bad++; $display("FAIL pause_third_cycle got=%h exp=1", bus.note_to_play);
        end
        bus.btn_play = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            n_cmp++;
            if (bus.note_to_play !== 4'd0 || bus.playing !== 1'b0 || bus.led_out !== 7'd0) begin
                n_bad++; $display("FAIL paused[%0d] got note=%h playing=%b led=%b exp 0/0/0", i, bus.note_to_play, bus.playing, bus.led_out);
            end
        end
        bus.btn_play = 1'b1;
        cyc();
        bus.btn_play = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            n_cmp++;
            if (bus.note_to_play !== ((i < 5) ? 4'd1 : 4'd0)) begin
                n_bad++; $display("FAIL resume[%0d] got=%h exp=%h", i, bus.note_to_play, ((i < 5) ? 4'd1 : 4'd0));
            end
        end
    endtask

    task automatic test_navigation();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cyc();
            if (bus.lib_addr != 6'd0 && bus.note_to_play != 4'd0) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++; $display("FAIL nav_reach_slot1 got=timeout exp=slot 1 playing");
        end
        bus.btn_prev = 1'b1;
        cyc();
        bus.btn_prev = 1'b0;
        cyc();
        n_cmp++;
        if ({bus.song_num, bus.lib_addr, bus.note_to_play, bus.playing} !== {2'd2, 6'd0, 4'd0, 1'b1}) begin
            n_bad++; $display("FAIL nav_prev_0to2 got song=%0d addr=%0d note=%h playing=%b exp 2/0/0/1",
                              bus.song_num, bus.lib_addr, bus.note_to_play, bus.playing);
        end
        cyc();
        n_cmp++;
        if (bus.note_to_play !== 4'd2) begin
            n_bad++; $display("FAIL nav_song2_note got=%h exp=2", bus.note_to_play);
        end
        bus.btn_next = 1'b1;
        cyc();
        bus.btn_next = 1'b0;
        cyc();
        n_cmp++;
        if ({bus.song_num, bus.lib_addr, bus.playing} !== {2'd0, 6'd0, 1'b1}) begin
            n_bad++; $display("FAIL nav_next_2to0 got song=%0d addr=%0d playing=%b exp 0/0/1", bus.song_num, bus.lib_addr, bus.playing);
        end
        bus.btn_next = 1'b1;
        cyc();
        bus.btn_next = 1'b0;
        cyc();
        n_cmp++;
        if ({bus.song_num, bus.note_to_play, bus.playing} !== {2'd1, 4'd0, 1'b1}) begin
            n_bad++; $display("FAIL nav_next_0to1 got song=%0d note=%h playing=%b exp 1/0/1", bus.song_num, bus.note_to_play, bus.playing);
        end
        cyc();
        n_cmp++;
        if (bus.playing !== 1'b0) begin
            n_bad++; $display("FAIL nav_song1_idle got playing=%b exp=0", bus.playing);
        end
        bus.btn_next = 1'b1;
        bus.btn_prev = 1'b1;
        cyc();
        bus.btn_next = 1'b0;
        bus.btn_prev = 1'b0;
        cyc();
        n_cmp++;
        if ({bus.song_num, bus.playing} !== {2'd2, 1'b0}) begin
            n_bad++; $display("FAIL nav_both_1to2 got song=%0d playing=%b exp 2/0", bus.song_num, bus.playing);
        end
    endtask

    task automatic test_empty_song();
        bus.btn_prev = 1'b1;
        cyc();
        bus.btn_prev = 1'b0;
        cyc();
        n_cmp++;
        if ({bus.song_num, bus.playing} !== {2'd1, 1'b0}) begin
            n_bad++; $display("FAIL empty_select got song=%0d playing=%b exp 1/0", bus.song_num, bus.playing);
        end
        bus.btn_play = 1'b1;
        cyc();
        bus.btn_play = 1'b0;
        cyc();
        n_cmp++;
        if ({bus.playing, bus.song_done} !== 2'b10) begin
            n_bad++; $display("FAIL empty_load got playing/done=%b exp=10", {bus.playing, bus.song_done});
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_cmp++;
            if ({bus.playing, bus.song_done, bus.note_to_play} !== 6'd0) begin
                n_bad++; $display("FAIL empty_idle[%0d] got playing=%b done=%b note=%h exp 0/0/0", i, bus.playing, bus.song_done, bus.note_to_play);
            end
        end
    endtask

    task automatic test_wrap_and_hold();
        logic [5:0] exp_addr;
        bus.btn_next = 1'b1;
        cyc();
        bus.btn_next = 1'b0;
        cyc();
        n_cmp++;
        if (bus.song_num !== 2'd2) begin
            n_bad++; $display("FAIL wrap_select got song=%0d exp=2", bus.song_num);
        end
        bus.btn_play = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            cyc();
            exp_addr = (k < 2 || k >= 30) ? 6'd0 : 6'((k - 2) / 7);
            n_cmp++;
            if (bus.playing !== (k >= 2)) begin
                n_bad++; $display("FAIL hold_playing[%0d] got=%b exp=%b", k, bus.playing, (k >= 2));
            end
            n_cmp++;
            if (bus.song_done !== (k == 30)) begin
                n_bad++; $display("FAIL wrap_done[%0d] got=%b exp=%b", k, bus.song_done, (k == 30));
            end
            n_cmp++;
            if (bus.lib_addr !== exp_addr) begin
                n_bad++; $display("FAIL wrap_addr[%0d] got=%0d exp=%0d", k, bus.lib_addr, exp_addr);
            end
            if (k == 20) bus.btn_play = 1'b0;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_song0_play();
        test_reset_mid_play();
        test_pause();
        test_navigation();
        test_empty_song();
        test_wrap_and_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
